character_ctl: RTL and testbench
================================

// Module: character_ctl
// PURPOSE
//  Per-frame movement controller for one playable character. Turns player inputs
//  (left/right/jump) into registered xpos/ypos/rotate once per frame; uses gravity
//  and a floor height supplied by the map lookup. Sits directly upstream of the
//  character draw stage, which consumes xpos, ypos, rotate and en.
// PARAMETERS
//  CHARACTER_HEIGHT  64   sprite height, px; feet row = ypos + CHARACTER_HEIGHT
//  CHARACTER_WIDTH   64   sprite width, px
//  X_INIT            32   spawn x (top-left)
//  Y_INIT            0    spawn y (top-left)
//  X_MAX             960  largest legal xpos (screen width - CHARACTER_WIDTH)
//  STEP_X            2    horizontal px per frame while a direction is held
//  JUMP_V            12   initial upward velocity, px/frame
//  GRAVITY           1    velocity change per frame, px/frame^2
//  MAX_FALL_V        12   terminal fall velocity, px/frame
// PORTS
//  clk         in   1   pixel clock
//  rst         in   1   reset, synchronous, active-high
//  frame_tick  in   1   one-clk pulse per frame (start of vblank)
//  start_game  in   1   high while a game is running
//  move_left   in   1   level, left held
//  move_right  in   1   level, right held
//  jump        in   1   level, jump held
//  floor_y     in   12  y of the surface top under the character (from map)
//  xpos        out  12  sprite top-left x
//  ypos        out  12  sprite top-left y
//  rotate      out  1   1 = facing left (draw stage mirrors horizontally)
//  en          out  1   1 = character drawn
//  airborne    out  1   1 in JUMP or FALL
// BEHAVIOUR
//  - Reset: xpos=X_INIT, ypos=Y_INIT, rotate=0, en=0, airborne=0, vel=0,
//    jump_req=0, state=IDLE. All outputs registered.
//  - jump_req: set on clk where jump rises (jump & ~jump_q); cleared on every
//    frame_tick after evaluation. Held jump does not re-jump; a new press is needed.
//  - Position/state update only on frame_tick; outputs change the clk after it.
//  - start_game low: next clk -> IDLE, positions back to init, en=0 (also mid-air).
//  - IDLE: on frame_tick with start_game=1 -> FALL, en=1, vel=0.
//  - Horizontal (GROUND, JUMP, FALL): left only -> xpos-=STEP_X, rotate=1; right
//    only -> xpos+=STEP_X, rotate=0; both/none -> xpos and rotate hold.
//    Clamp to [0, X_MAX]; no wrap-around (xpos=1, left -> 0).
//  - GROUND: jump_req -> JUMP, vel=JUMP_V. Else if ypos+HEIGHT < floor_y
//    (walked off edge) -> FALL, vel=0. Else ypos=floor_y-HEIGHT.
//  - JUMP: if vel > ypos -> ypos=0, vel=0, FALL (ceiling). Else ypos-=vel,
//    vel-=GRAVITY (saturate at 0); vel reaching 0 -> FALL.
//  - FALL: vel=min(vel+GRAVITY, MAX_FALL_V); if ypos+vel+HEIGHT >= floor_y ->
//    ypos=floor_y-HEIGHT, vel=0, GROUND (landing snaps exactly). Else ypos+=vel.
//  - jump_req in JUMP/FALL is ignored and cleared (no double jump).
//  - Arithmetic in 13 bits unsigned before clamp; vel 5 bits unsigned, direction
//    implied by state.
//  - floor_y < HEIGHT: treat as floor_y=HEIGHT (ypos never underflows).
//  - frame_tick and jump rise on same clk: that jump counts in the current frame.
// STRUCTURE
//  - Package characterPkg: typedef enum logic [1:0] {IDLE, GROUND, JUMP, FALL}
//    char_state_t; shared physics constants (JUMP_V, GRAVITY, MAX_FALL_V defaults).
//  - Sub-module edge_detect (1-bit rising-edge, registered) for jump; rest inline.
//  - Two-process style: always_ff state/regs, always_comb next-state/positions.
// TESTING
//  - Reset, start_game=1, tick, floor_y=600 -> FALL; ypos accumulates 1,3,6..;
//    lands with ypos=536, GROUND, airborne=0.
//  - GROUND at x=100, right held 10 ticks -> xpos=120, rotate=0; then left 1 tick
//    -> xpos=118, rotate=1; both held -> xpos, rotate unchanged.
//  - xpos=1, left held -> 0 and stays 0; xpos=959, right held -> 960 (X_MAX).
//  - GROUND ypos=536, jump pulse -> next tick ypos=524, apex after 12 ticks
//    (ypos=458), then falls back to exactly 536; held jump -> one jump only.
//  - JUMP with ypos=5, vel=12 -> ypos=0, FALL; floor_y drops to 700 while on
//    ground -> FALL, lands at ypos=636.
//  - start_game deasserted mid-jump -> next clk IDLE, xpos=32, ypos=0, en=0;
//    rst mid-FALL -> reset values on next clk.

Source files
------------

// File: rtl/character_ctl_pkg.sv
// Shared state encoding, datapath widths and physics defaults for the character controller.
package character_ctl_pkg;

  typedef enum logic [1:0] {StIdle, StGround, StJump, StFall} char_state_t;

  localparam int unsigned CoordW = 12;
  // One spare bit so sums and differences can be range-checked before clamping.
  localparam int unsigned ArithW = 13;
  localparam int unsigned VelW   = 5;

  localparam int unsigned JumpVDef    = 12;
  localparam int unsigned GravityDef  = 1;
  localparam int unsigned MaxFallVDef = 12;

  function automatic logic [ArithW-1:0] min_a(input logic [ArithW-1:0] a,
                                              input logic [ArithW-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/character_ctl_edge_detect.sv
// Rising-edge detector: registers the input and flags the clk where it goes 0 -> 1.
module character_ctl_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/character_ctl.sv
// Per-frame movement controller: turns left/right/jump into registered sprite position,
// facing and visibility, with gravity and a map-supplied floor height.
module character_ctl
  import character_ctl_pkg::*;
#(
  parameter int unsigned CharacterHeight = 64,
  parameter int unsigned CharacterWidth  = 64,
  parameter int unsigned ScreenWidth     = 1024,
  parameter int unsigned XInit           = 32,
  parameter int unsigned YInit           = 0,
  parameter int unsigned XMax            = ScreenWidth - CharacterWidth,
  parameter int unsigned StepX           = 2,
  parameter int unsigned JumpV           = JumpVDef,
  parameter int unsigned Gravity         = GravityDef,
  parameter int unsigned MaxFallV        = MaxFallVDef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick_i,
  input  logic              start_game_i,
  input  logic              move_left_i,
  input  logic              move_right_i,
  input  logic              jump_i,
  input  logic [CoordW-1:0] floor_y_i,
  output logic [CoordW-1:0] xpos_o,
  output logic [CoordW-1:0] ypos_o,
  output logic              rotate_o,
  output logic              en_o,
  output logic              airborne_o
);

  localparam logic [ArithW-1:0] HeightA   = ArithW'(CharacterHeight);
  localparam logic [ArithW-1:0] StepA     = ArithW'(StepX);
  localparam logic [ArithW-1:0] XMaxA     = ArithW'(XMax);
  localparam logic [ArithW-1:0] GravA     = ArithW'(Gravity);
  localparam logic [ArithW-1:0] MaxFallA  = ArithW'(MaxFallV);
  localparam logic [ArithW-1:0] XInitA    = ArithW'(XInit);
  localparam logic [ArithW-1:0] YInitA    = ArithW'(YInit);
  localparam logic [ArithW-1:0] JumpVA    = ArithW'(JumpV);

  char_state_t       state_q, state_d;
  logic [CoordW-1:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic [VelW-1:0]   vel_q, vel_d;
  logic              rotate_q, rotate_d, en_q, en_d, airborne_q, airborne_d;
  logic              jump_req_q, jump_req_d;
  logic              jump_rise, jump_now;

  logic [ArithW-1:0] x_a, y_a, vel_a, floor_a, land_y;
  logic [ArithW-1:0] x_left, x_right, y_rise, vel_rise, vel_fall, y_fall;
  logic [ArithW-1:0] x_next, y_next, vel_next;
  logic              unused_msbs;

  character_ctl_edge_detect u_jump_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (jump_i),
    .rise_o (jump_rise)
  );

  // A press on the same clk as frame_tick still counts for this frame.
  assign jump_now = jump_req_q | jump_rise;

  assign x_a      = ArithW'(xpos_q);
  assign y_a      = ArithW'(ypos_q);
  assign vel_a    = ArithW'(vel_q);
  // A floor above the sprite height would put the top edge above row 0.
  assign floor_a  = (ArithW'(floor_y_i) < HeightA) ? HeightA : ArithW'(floor_y_i);
  assign land_y   = floor_a - HeightA;
  assign x_left   = (x_a < StepA) ? '0 : x_a - StepA;
  assign x_right  = min_a(x_a + StepA, XMaxA);
  assign y_rise   = y_a - vel_a;
  assign vel_rise = (vel_a < GravA) ? '0 : vel_a - GravA;
  assign vel_fall = min_a(vel_a + GravA, MaxFallA);
  assign y_fall   = y_a + vel_fall;

  always_comb begin
    state_d    = state_q;
    x_next     = x_a;
    y_next     = y_a;
    vel_next   = vel_a;
    rotate_d   = rotate_q;
    en_d       = en_q;
    jump_req_d = jump_now;

    if (!start_game_i) begin
      state_d  = StIdle;
      x_next   = XInitA;
      y_next   = YInitA;
      vel_next = '0;
      rotate_d = 1'b0;
      en_d     = 1'b0;
    end else if (frame_tick_i) begin
      jump_req_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          state_d  = StFall;
          en_d     = 1'b1;
          vel_next = '0;
        end
        StGround: begin
          if (jump_now) begin
            state_d  = StJump;
            vel_next = JumpVA;
          end else if (y_a + HeightA < floor_a) begin
            state_d  = StFall;
            vel_next = '0;
          end else begin
            y_next = land_y;
          end
        end
        StJump: begin
          if (vel_a > y_a) begin
            state_d  = StFall;
            y_next   = '0;
            vel_next = '0;
          end else begin
            y_next   = y_rise;
            vel_next = vel_rise;
            if (vel_rise == '0) state_d = StFall;
          end
        end
        StFall: begin
          if (y_fall + HeightA >= floor_a) begin
            state_d  = StGround;
            y_next   = land_y;
            vel_next = '0;
          end else begin
            y_next   = y_fall;
            vel_next = vel_fall;
          end
        end
      endcase

      if (state_q != StIdle) begin
        if (move_left_i && !move_right_i) begin
          x_next   = x_left;
          rotate_d = 1'b1;
        end else if (move_right_i && !move_left_i) begin
          x_next   = x_right;
          rotate_d = 1'b0;
        end
      end
    end

    xpos_d     = x_next[CoordW-1:0];
    ypos_d     = y_next[CoordW-1:0];
    vel_d      = vel_next[VelW-1:0];
    airborne_d = (state_d == StJump) || (state_d == StFall);
  end

  // Results are range-limited above, so the spare arithmetic bits are always zero.
  assign unused_msbs = ^{x_next[ArithW-1], y_next[ArithW-1], vel_next[ArithW-1:VelW]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      xpos_q     <= XInitA[CoordW-1:0];
      ypos_q     <= YInitA[CoordW-1:0];
      vel_q      <= '0;
      rotate_q   <= 1'b0;
      en_q       <= 1'b0;
      airborne_q <= 1'b0;
      jump_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      vel_q      <= vel_d;
      rotate_q   <= rotate_d;
      en_q       <= en_d;
      airborne_q <= airborne_d;
      jump_req_q <= jump_req_d;
    end
  end

  assign xpos_o     = xpos_q;
  assign ypos_o     = ypos_q;
  assign rotate_o   = rotate_q;
  assign en_o       = en_q;
  assign airborne_o = airborne_q;

endmodule

// File: tb/tb_character_ctl.sv
// Bench for character_ctl: reset, physics table, directed corner sequences, then random
// stimulus against a frame-level reference model. A second instance spawns at x=31.
module tb_character_ctl;

  logic        clk = 1'b0;
  logic        rst, frame_tick, start_game, move_left, move_right, jump;
  logic [11:0] floor_y;
  logic [11:0] xpos, ypos, xpos_b, ypos_b;
  logic        rotate, en, airborne, rotate_b, en_b, airborne_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  character_ctl u_dut (
    .clk(clk), .rst(rst), .frame_tick_i(frame_tick), .start_game_i(start_game),
    .move_left_i(move_left), .move_right_i(move_right), .jump_i(jump), .floor_y_i(floor_y),
    .xpos_o(xpos), .ypos_o(ypos), .rotate_o(rotate), .en_o(en), .airborne_o(airborne)
  );

  character_ctl #(.XInit(31)) u_dut_b (
    .clk(clk), .rst(rst), .frame_tick_i(frame_tick), .start_game_i(start_game),
    .move_left_i(move_left), .move_right_i(move_right), .jump_i(jump), .floor_y_i(floor_y),
    .xpos_o(xpos_b), .ypos_o(ypos_b), .rotate_o(rotate_b), .en_o(en_b),
    .airborne_o(airborne_b)
  );

  // Reference model: one frame of the movement rules in plain integers.
  localparam int MIdle = 0, MGround = 1, MRise = 2, MDrop = 3;
  int m_mode, m_y, m_v;
  int m_x[2];
  bit m_rot, m_en, m_req, m_prev;

  task automatic model_home();
    m_mode = MIdle; m_x[0] = 32; m_x[1] = 31; m_y = 0; m_v = 0; m_rot = 0; m_en = 0;
  endtask

  task automatic model_step();
    int fl, prev_mode;
    bit rise, want;
    rise = jump && !m_prev;
    if (rst) begin
      m_prev = 0; m_req = 0; model_home();
      return;
    end
    m_prev = jump;
    m_req  = m_req || rise;
    if (!start_game) begin
      model_home();
    end else if (frame_tick) begin
      want = m_req; m_req = 0;
      fl = (int'(floor_y) < 64) ? 64 : int'(floor_y);
      prev_mode = m_mode;
      case (m_mode)
        MIdle: begin m_mode = MDrop; m_en = 1; m_v = 0; end
        MGround: begin
          if (want) begin m_mode = MRise; m_v = 12; end
          else if (m_y + 64 < fl) begin m_mode = MDrop; m_v = 0; end
          else m_y = fl - 64;
        end
        MRise: begin
          if (m_v > m_y) begin m_y = 0; m_v = 0; m_mode = MDrop; end
          else begin
            m_y = m_y - m_v;
            m_v = (m_v > 0) ? m_v - 1 : 0;
            if (m_v == 0) m_mode = MDrop;
          end
        end
        default: begin
          m_v = (m_v + 1 > 12) ? 12 : m_v + 1;
          if (m_y + m_v + 64 >= fl) begin m_y = fl - 64; m_v = 0; m_mode = MGround; end
          else m_y = m_y + m_v;
        end
      endcase
      if (prev_mode != MIdle) begin
        for (int i = 0; i < 2; i++) begin
          if (move_left && !move_right) begin
            m_x[i] = (m_x[i] < 2) ? 0 : m_x[i] - 2; m_rot = 1;
          end else if (move_right && !move_left) begin
            m_x[i] = (m_x[i] + 2 > 960) ? 960 : m_x[i] + 2; m_rot = 0;
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
  endtask

  task automatic wait_land(input int max_ticks);
    int n = 0;
    while (airborne && n < max_ticks) begin
      tick();
      n++;
    end
    check("land_within_bound", int'(airborne), 0);
  endtask

  task automatic compare_model();
    bit m_air;
    m_air = (m_mode == MRise) || (m_mode == MDrop);
    check("rnd_xpos", int'(xpos), m_x[0]);
    check("rnd_xpos_b", int'(xpos_b), m_x[1]);
    check("rnd_ypos", int'(ypos), m_y);
    check("rnd_ypos_b", int'(ypos_b), m_y);
    check("rnd_rotate", int'(rotate), int'(m_rot));
    check("rnd_en", int'(en), int'(m_en));
    check("rnd_airborne", int'(airborne), int'(m_air));
    check("rnd_airborne_b", int'(airborne_b), int'(m_air));
  endtask

  typedef struct {
    bit l;
    bit r;
    int fl;
    int x;
    int y;
    bit rot;
    bit air;
  } vec_t;

  vec_t vecs[25];

  initial begin
    for (int i = 0; i < 10; i++) vecs[i] = '{0, 1, 600, 102 + 2 * i, 536, 0, 0};
    vecs[10] = '{1, 0, 600, 118, 536, 1, 0};
    vecs[11] = '{1, 1, 600, 118, 536, 1, 0};
    vecs[12] = '{0, 0, 600, 118, 536, 1, 0};
    vecs[13] = '{0, 1, 600, 120, 536, 0, 0};
    vecs[14] = '{0, 0, 610, 120, 536, 0, 1};  // floor drops away under the feet
    vecs[15] = '{0, 0, 610, 120, 537, 0, 1};
    vecs[16] = '{0, 0, 610, 120, 539, 0, 1};
    vecs[17] = '{0, 0, 610, 120, 542, 0, 1};
    vecs[18] = '{0, 0, 610, 120, 546, 0, 0};
    vecs[19] = '{0, 0, 590, 120, 526, 0, 0};  // floor rises: snap up
    vecs[20] = '{0, 0, 600, 120, 526, 0, 1};
    vecs[21] = '{0, 0, 600, 120, 527, 0, 1};
    vecs[22] = '{0, 0, 600, 120, 529, 0, 1};
    vecs[23] = '{0, 0, 600, 120, 532, 0, 1};
    vecs[24] = '{0, 0, 600, 120, 536, 0, 0};

    rst = 1; frame_tick = 0; start_game = 0; move_left = 0; move_right = 0; jump = 0;
    floor_y = 12'd600;
    cycle(); cycle();
    rst = 0;
    check("rst_xpos", int'(xpos), 32);
    check("rst_xpos_b", int'(xpos_b), 31);
    check("rst_ypos", int'(ypos), 0);
    check("rst_rotate", int'(rotate), 0);
    check("rst_en", int'(en), 0);
    check("rst_airborne", int'(airborne), 0);

    // Spawn and first fall.
    start_game = 1;
    tick();
    check("spawn_en", int'(en), 1);
    check("spawn_airborne", int'(airborne), 1);
    check("spawn_ypos", int'(ypos), 0);
    tick(); check("fall_y1", int'(ypos), 1);
    tick(); check("fall_y3", int'(ypos), 3);
    tick(); check("fall_y6", int'(ypos), 6);
    wait_land(80);
    check("first_land_ypos", int'(ypos), 536);

    move_right = 1;
    repeat (34) tick();
    move_right = 0;
    check("walk_to_100", int'(xpos), 100);

    foreach (vecs[i]) begin
      move_left = vecs[i].l; move_right = vecs[i].r; floor_y = 12'(vecs[i].fl);
      tick();
      check($sformatf("vec%0d_xpos", i), int'(xpos), vecs[i].x);
      check($sformatf("vec%0d_xpos_b", i), int'(xpos_b), vecs[i].x - 1);
      check($sformatf("vec%0d_ypos", i), int'(ypos), vecs[i].y);
      check($sformatf("vec%0d_rotate", i), int'(rotate), int'(vecs[i].rot));
      check($sformatf("vec%0d_airborne", i), int'(airborne), int'(vecs[i].air));
    end
    move_left = 0; move_right = 0;

    // Jump pressed on the tick clk itself, then held throughout.
    jump = 1;
    tick();
    check("jump_start_air", int'(airborne), 1);
    check("jump_start_ypos", int'(ypos), 536);
    tick();
    check("jump_first_ypos", int'(ypos), 524);
    repeat (11) tick();
    check("jump_apex_ypos", int'(ypos), 458);
    check("jump_apex_air", int'(airborne), 1);
    repeat (11) tick();
    check("jump_desc_ypos", int'(ypos), 524);
    tick();
    check("jump_land_ypos", int'(ypos), 536);
    check("jump_land_air", int'(airborne), 0);
    repeat (2) tick();
    check("held_jump_no_rejump", int'(airborne), 0);
    jump = 0;

    // Ceiling hit from a low ground.
    floor_y = 12'd69;
    tick();
    check("low_floor_ypos", int'(ypos), 5);
    jump = 1; cycle(); jump = 0;
    tick();
    check("ceil_jump_air", int'(airborne), 1);
    tick();
    check("ceil_ypos", int'(ypos), 0);
    check("ceil_air", int'(airborne), 1);
    wait_land(20);
    check("ceil_land_ypos", int'(ypos), 5);
    floor_y = 12'd700;
    tick();
    check("edge_walk_air", int'(airborne), 1);
    wait_land(80);
    check("land_700_ypos", int'(ypos), 636);
    floor_y = 12'd10;
    tick();
    check("floor_below_height_ypos", int'(ypos), 0);
    floor_y = 12'd600;
    tick();
    wait_land(80);
    check("reland_600_ypos", int'(ypos), 536);

    // Right boundary: 958/957 -> 960/959 -> 960/960.
    move_right = 1;
    repeat (419) tick();
    check("right_958", int'(xpos), 958);
    check("right_b_957", int'(xpos_b), 957);
    tick();
    check("right_clamp_960", int'(xpos), 960);
    check("right_b_959", int'(xpos_b), 959);
    tick();
    check("right_b_clamp_960", int'(xpos_b), 960);
    check("right_stay_960", int'(xpos), 960);
    move_right = 0;

    // Game stop returns to spawn, then left boundary: 2/1 -> 0/0 -> 0/0.
    start_game = 0;
    cycle();
    check("stop_xpos", int'(xpos), 32);
    check("stop_xpos_b", int'(xpos_b), 31);
    check("stop_ypos", int'(ypos), 0);
    check("stop_en", int'(en), 0);
    start_game = 1;
    tick();
    wait_land(80);
    move_left = 1;
    repeat (15) tick();
    check("left_2", int'(xpos), 2);
    check("left_b_1", int'(xpos_b), 1);
    tick();
    check("left_clamp_0", int'(xpos), 0);
    check("left_b_clamp_0", int'(xpos_b), 0);
    tick();
    check("left_stay_0", int'(xpos), 0);
    check("left_rotate", int'(rotate), 1);
    move_left = 0;

    // start_game dropped mid-jump.
    jump = 1; cycle(); jump = 0;
    tick(); tick();
    check("midjump_ypos", int'(ypos), 524);
    start_game = 0;
    cycle();
    check("abort_xpos", int'(xpos), 32);
    check("abort_ypos", int'(ypos), 0);
    check("abort_en", int'(en), 0);
    check("abort_air", int'(airborne), 0);

    // rst mid-fall.
    start_game = 1;
    tick(); tick(); tick();
    check("prefall_ypos", int'(ypos), 3);
    rst = 1;
    cycle();
    rst = 0;
    check("rst_fall_xpos", int'(xpos), 32);
    check("rst_fall_ypos", int'(ypos), 0);
    check("rst_fall_en", int'(en), 0);
    check("rst_fall_air", int'(airborne), 0);

    for (int n = 0; n < 4000; n++) begin
      rst        = ($urandom_range(0, 999) == 0);
      start_game = ($urandom_range(0, 299) != 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) move_left = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) move_right = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) jump = ~jump;
      if ($urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 5))
          0: floor_y = 12'd20;
          1: floor_y = 12'd64;
          2: floor_y = 12'd300;
          3: floor_y = 12'd600;
          4: floor_y = 12'd700;
          default: floor_y = 12'($urandom_range(0, 4095));
        endcase
      end
      cycle();
      compare_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
